pwm_capture: RTL

- Measurement block for the receive side of a PWM link: samples an incoming PWM waveform and recovers its period and high time, counted in pwm_clk cycles.
- Its outputs map directly onto the generator's (range, value) pair: period = range+1, high = value.
- Sits on the fabric side of a PWM input pin; results are read by a register/bus wrapper.

---
 rtl/pwm_capture.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/pwm_capture.sv
// PWM input capture: recovers rise-to-rise period and high time in pwm_clk cycles.
// Optional glitch filter on the synchronized input is enabled by defining PWM_CAP_GLITCH_FILTER_EN.
module pwm_capture #(
    parameter int CNT_W    = 16,
    parameter int FILT_LEN = 4
) (
    input  logic             pwm_clk,
    input  logic             pwm_reset,
    input  logic             cap_en,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] cap_period,
    output logic [CNT_W-1:0] cap_high,
    output logic             cap_valid,
    output logic             cap_timeout,
    output logic             cap_level
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic {
        IDLE,
        MEAS
    } state_t;

    if (FILT_LEN < 2 || FILT_LEN > 15) begin : g_filt_len_check
        $error("pwm_capture: FILT_LEN must be in 2..15");
    end

    state_t           state_q, state_d;
    logic             s1_q, s2_q, s3_q;
    logic             lvl, rise;
    logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
    logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
    logic [CNT_W-1:0] cap_period_q, cap_period_d;
    logic [CNT_W-1:0] cap_high_q, cap_high_d;
    logic             cap_valid_q, cap_valid_d;
    logic             cap_timeout_q, cap_timeout_d;

`ifdef PWM_CAP_GLITCH_FILTER_EN
    localparam logic [3:0] FILT_LAST = 4'(FILT_LEN - 1);

    logic [3:0] filt_cnt_q, filt_cnt_d;
    logic       filt_lvl_q, filt_lvl_d;

    // The filtered level only follows s2 after FILT_LEN consecutive cycles of disagreement.
    always_comb begin
        filt_cnt_d = '0;
        filt_lvl_d = filt_lvl_q;
        if (s2_q != filt_lvl_q) begin
            if (filt_cnt_q == FILT_LAST) begin
                filt_lvl_d = s2_q;
            end else begin
                filt_cnt_d = filt_cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge pwm_clk or posedge pwm_reset) begin
        if (pwm_reset) begin
            filt_cnt_q <= '0;
            filt_lvl_q <= 1'b0;
        end else begin
            filt_cnt_q <= filt_cnt_d;
            filt_lvl_q <= filt_lvl_d;
        end
    end

    assign lvl = filt_lvl_q;
`else
    assign lvl = s2_q;
`endif

    assign rise = lvl & ~s3_q;

    always_comb begin
        state_d       = state_q;
        period_cnt_d  = period_cnt_q;
        high_cnt_d    = high_cnt_q;
        cap_period_d  = cap_period_q;
        cap_high_d    = cap_high_q;
        cap_valid_d   = 1'b0;
        cap_timeout_d = cap_timeout_q;
        if (!cap_en) begin
            state_d      = IDLE;
            period_cnt_d = '0;
            high_cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    period_cnt_d = '0;
                    high_cnt_d   = '0;
                    if (rise) begin
                        state_d      = MEAS;
                        period_cnt_d = CNT_ONE;
                        high_cnt_d   = CNT_ONE;
                    end
                end
                MEAS: begin
                    // A rise on the saturation cycle still counts as a valid capture.
                    if (rise) begin
                        cap_period_d  = period_cnt_q;
                        cap_high_d    = high_cnt_q;
                        cap_valid_d   = 1'b1;
                        cap_timeout_d = 1'b0;
                        period_cnt_d  = CNT_ONE;
                        high_cnt_d    = CNT_ONE;
                    end else if (period_cnt_q == CNT_MAX) begin
                        cap_timeout_d = 1'b1;
                        state_d       = IDLE;
                        period_cnt_d  = '0;
                        high_cnt_d    = '0;
                    end else begin
                        period_cnt_d = period_cnt_q + CNT_ONE;
                        if (lvl && high_cnt_q != CNT_MAX) begin
                            high_cnt_d = high_cnt_q + CNT_ONE;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge pwm_clk or posedge pwm_reset) begin
        if (pwm_reset) begin
            s1_q          <= 1'b0;
            s2_q          <= 1'b0;
            s3_q          <= 1'b0;
            state_q       <= IDLE;
            period_cnt_q  <= '0;
            high_cnt_q    <= '0;
            cap_period_q  <= '0;
            cap_high_q    <= '0;
            cap_valid_q   <= 1'b0;
            cap_timeout_q <= 1'b0;
        end else begin
            s1_q          <= pwm_in;
            s2_q          <= s1_q;
            s3_q          <= lvl;
            state_q       <= state_d;
            period_cnt_q  <= period_cnt_d;
            high_cnt_q    <= high_cnt_d;
            cap_period_q  <= cap_period_d;
            cap_high_q    <= cap_high_d;
            cap_valid_q   <= cap_valid_d;
            cap_timeout_q <= cap_timeout_d;
        end
    end

    assign cap_period  = cap_period_q;
    assign cap_high    = cap_high_q;
    assign cap_valid   = cap_valid_q;
    assign cap_timeout = cap_timeout_q;
    assign cap_level   = lvl;

endmodule
